// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: control inputs and status/strobe outputs of the stage sequencer.
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = 3,
  parameter int CNT_W      = 16
);
  logic                  run;
  logic                  stall;
  logic                  flush;
  logic [NUM_STAGES-1:0] skip_mask;
  logic [NUM_STAGES-1:0] stage_go;
  logic [STAGE_W-1:0]    stage_idx;
  logic                  busy;
  logic                  retire;
  logic [CNT_W-1:0]      retire_count;
  logic [CNT_W-1:0]      cycle_count;
  modport master (
    output run, stall, flush, skip_mask,
    input  stage_go, stage_idx, busy, retire, retire_count, cycle_count
  );
  modport slave (
    input  run, stall, flush, skip_mask,
    output stage_go, stage_idx, busy, retire, retire_count, cycle_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: walks an instruction through up to NUM_STAGES multicycle stages with skip, stall and flush.
module stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = 3,
  parameter int CNT_W      = 16
) (
  input logic            clk,
  input logic            nreset,
  stage_sequencer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e                state_q, state_d;
  logic [STAGE_W-1:0]    idx_q, idx_d, nxt;
  logic [NUM_STAGES-1:0] mask_q, mask_d, mask_eff;
  logic [CNT_W-1:0]      rc_q, rc_d, cc_q, cc_d;
  logic                  go, last;
  // Stage 0 decides its successor from the live mask, since the latched copy is only written on this edge.
  always_comb begin
    mask_eff = idx_q == '0 ? bus.skip_mask & ~NUM_STAGES'(1) : mask_q;
    nxt = '0;
    last = 1'b1;
    for (int j = NUM_STAGES - 1; j > 0; j--)
      if (j > int'(idx_q) && !mask_eff[j]) begin
        nxt = STAGE_W'(j);
        last = 1'b0;
      end
  end
  assign go               = state_q == RUN && !bus.stall && !bus.flush;
  assign bus.stage_go     = go ? (NUM_STAGES'(1) << idx_q) : '0;
  assign bus.retire       = go && last;
  assign bus.busy         = state_q == RUN;
  assign bus.stage_idx    = idx_q;
  assign bus.retire_count = rc_q;
  assign bus.cycle_count  = cc_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    rc_d    = rc_q;
    cc_d    = cc_q;
    if (state_q == IDLE) begin
      state_d = bus.run ? RUN : IDLE;
      idx_d   = '0;
    end else begin
      cc_d   = cc_q + CNT_W'(1);
      mask_d = go && idx_q == '0 ? mask_eff : mask_q;
      rc_d   = bus.retire ? rc_q + CNT_W'(1) : rc_q;
      if (bus.flush || bus.retire) begin
        idx_d   = '0;
        state_d = bus.run ? RUN : IDLE;
      end else if (go) idx_d = nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      rc_q    <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      rc_q    <= rc_d;
      cc_q    <= cc_d;
    end
  end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed scenarios with hand-computed strobes, indices and counter values.
module tb_stage_sequencer;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  stage_sequencer_if #(.NUM_STAGES(5), .STAGE_W(3), .CNT_W(4)) bus ();
  stage_sequencer #(.NUM_STAGES(5), .STAGE_W(3), .CNT_W(4)) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );
  task automatic test_reset;
    nreset = 1'b0; bus.run = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0; bus.skip_mask = '0;
    repeat (2) @(negedge clk);
    bus.run = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_chk++; if (bus.stage_go !== 5'b0) begin n_fail++; $display("FAIL reset_go got %b want 00000", bus.stage_go); end
    n_chk++; if (bus.retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire got %b want 0", bus.retire); end
    n_chk++; if (bus.stage_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", bus.stage_idx); end
    n_chk++; if (bus.retire_count !== 4'd0 || bus.cycle_count !== 4'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.retire_count, bus.cycle_count); end
  endtask
  task automatic test_basic;
    @(negedge clk);
    nreset = 1'b1; bus.run = 1'b1; bus.skip_mask = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) bus.run = 1'b0;
      #1;
      n_chk++; if (bus.stage_go !== (5'b1 << i)) begin n_fail++; $display("FAIL basic_go[%0d] got %b want %b", i, bus.stage_go, 5'b1 << i); end
      n_chk++; if (bus.retire !== (i == 4)) begin n_fail++; $display("FAIL basic_retire[%0d] got %b want %b", i, bus.retire, i == 4); end
    end
    @(negedge clk); #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.stage_go !== 5'b0) begin n_fail++; $display("FAIL basic_idle got busy=%b go=%b want 0/00000", bus.busy, bus.stage_go); end
    n_chk++; if (bus.retire_count !== 4'd1) begin n_fail++; $display("FAIL basic_rc got %0d want 1", bus.retire_count); end
    n_chk++; if (bus.cycle_count !== 4'd5) begin n_fail++; $display("FAIL basic_cc got %0d want 5", bus.cycle_count); end
  endtask
  task automatic test_skip;
    logic [4:0] exp_go [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b10000};
    bus.run = 1'b1; bus.skip_mask = 5'b01001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.skip_mask = 5'b11110;
      if (i == 3) bus.run = 1'b0;
      #1;
      n_chk++; if (bus.stage_go !== exp_go[i]) begin n_fail++; $display("FAIL skip_go[%0d] got %b want %b", i, bus.stage_go, exp_go[i]); end
      n_chk++; if (bus.retire !== (i == 3)) begin n_fail++; $display("FAIL skip_retire[%0d] got %b want %b", i, bus.retire, i == 3); end
    end
    @(negedge clk); #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.retire_count !== 4'd2) begin n_fail++; $display("FAIL skip_end got busy=%b rc=%0d want 0/2", bus.busy, bus.retire_count); end
    bus.skip_mask = '0;
  endtask
  task automatic test_stall;
    logic [4:0] exp_go [8]  = '{5'b00001, 5'b00010, 5'b0, 5'b0, 5'b0, 5'b00100, 5'b01000, 5'b10000};
    logic [2:0] exp_idx [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1; bus.run = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.stall = c >= 2 && c <= 4;
      if (c == 7) bus.run = 1'b0;
      #1;
      n_chk++; if (bus.stage_go !== exp_go[c] || bus.stage_idx !== exp_idx[c]) begin n_fail++; $display("FAIL stall_c%0d got go=%b idx=%0d want %b/%0d", c + 1, bus.stage_go, bus.stage_idx, exp_go[c], exp_idx[c]); end
      n_chk++; if (bus.retire !== (c == 7)) begin n_fail++; $display("FAIL stall_retire_c%0d got %b want %b", c + 1, bus.retire, c == 7); end
    end
    @(negedge clk); #1;
    n_chk++; if (bus.cycle_count !== 4'd8 || bus.retire_count !== 4'd1) begin n_fail++; $display("FAIL stall_counts got cc=%0d rc=%0d want 8/1", bus.cycle_count, bus.retire_count); end
  endtask
  task automatic test_flush;
    bus.run = 1'b1;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    n_chk++; if (bus.stage_idx !== 3'd3 || bus.stage_go !== 5'b0 || bus.retire !== 1'b0) begin n_fail++; $display("FAIL flush_cycle got idx=%0d go=%b ret=%b want 3/00000/0", bus.stage_idx, bus.stage_go, bus.retire); end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    n_chk++; if (bus.stage_idx !== 3'd0 || bus.stage_go !== 5'b00001 || bus.retire_count !== 4'd1) begin n_fail++; $display("FAIL flush_next got idx=%0d go=%b rc=%0d want 0/00001/1", bus.stage_idx, bus.stage_go, bus.retire_count); end
    @(negedge clk);
    bus.flush = 1'b1; bus.run = 1'b0;
    #1;
    n_chk++; if (bus.stage_go !== 5'b0) begin n_fail++; $display("FAIL flush2_go got %b want 00000", bus.stage_go); end
    @(negedge clk);
    bus.stall = 1'b1;
    #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.stage_idx !== 3'd0 || bus.retire_count !== 4'd1) begin n_fail++; $display("FAIL flush_idle got busy=%b idx=%0d rc=%0d want 0/0/1", bus.busy, bus.stage_idx, bus.retire_count); end
    @(negedge clk); #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.stage_go !== 5'b0 || bus.retire !== 1'b0) begin n_fail++; $display("FAIL idle_ignores got busy=%b go=%b ret=%b want 0/00000/0", bus.busy, bus.stage_go, bus.retire); end
    bus.stall = 1'b0; bus.flush = 1'b0;
  endtask
  task automatic test_drop_run;
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) bus.run = 1'b0;
      #1;
      n_chk++; if (bus.stage_go !== (5'b1 << i) || bus.retire !== (i == 4)) begin n_fail++; $display("FAIL drop_s%0d got go=%b ret=%b want %b/%b", i, bus.stage_go, bus.retire, 5'b1 << i, i == 4); end
    end
    @(negedge clk); #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.stage_go !== 5'b0 || bus.retire_count !== 4'd2) begin n_fail++; $display("FAIL drop_idle got busy=%b go=%b rc=%0d want 0/00000/2", bus.busy, bus.stage_go, bus.retire_count); end
  endtask
  task automatic test_wrap;
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1; bus.run = 1'b1; bus.skip_mask = 5'b11110;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) bus.run = 1'b0;
      #1;
      n_chk++; if (bus.retire !== 1'b1 || bus.stage_go !== 5'b00001) begin n_fail++; $display("FAIL wrap_retire[%0d] got ret=%b go=%b want 1/00001", i, bus.retire, bus.stage_go); end
      if (i == 8) begin
        n_chk++; if (bus.retire_count !== 4'd8) begin n_fail++; $display("FAIL wrap_mid_rc got %0d want 8", bus.retire_count); end
      end
    end
    @(negedge clk); #1;
    n_chk++; if (bus.retire_count !== 4'd0 || bus.cycle_count !== 4'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL wrap_end got rc=%0d cc=%0d busy=%b want 0/0/0", bus.retire_count, bus.cycle_count, bus.busy); end
    bus.skip_mask = '0;
  endtask
  task automatic test_reset_mid;
    bus.run = 1'b1;
    repeat (3) @(negedge clk);
    nreset = 1'b0;
    #1;
    n_chk++; if (bus.stage_go !== 5'b00100) begin n_fail++; $display("FAIL rmid_before got %b want 00100", bus.stage_go); end
    @(negedge clk);
    nreset = 1'b1; bus.run = 1'b0;
    #1;
    n_chk++; if (bus.stage_go !== 5'b0 || bus.busy !== 1'b0 || bus.retire !== 1'b0 || bus.stage_idx !== 3'd0) begin n_fail++; $display("FAIL rmid_after got go=%b busy=%b ret=%b idx=%0d want 00000/0/0/0", bus.stage_go, bus.busy, bus.retire, bus.stage_idx); end
    n_chk++; if (bus.retire_count !== 4'd0 || bus.cycle_count !== 4'd0) begin n_fail++; $display("FAIL rmid_counts got rc=%0d cc=%0d want 0/0", bus.retire_count, bus.cycle_count); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_skip;
    test_stall;
    test_flush;
    test_drop_run;
    test_wrap;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The parameter NUM_STAGES SHALL default to 5 and set the number of multicycle stages; the legal range is 2..8.
REQ-002 The parameter STAGE_W SHALL default to 3 and set the stage index width; it SHALL satisfy 2^STAGE_W >= NUM_STAGES.
REQ-003 The parameter CNT_W SHALL default to 16 and set the width of both performance counters.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 nreset  input  1  SHALL be the synchronous, active-low reset.
REQ-007 run  input  1  SHALL, when high, request continuous instruction sequencing.
REQ-008 stall  input  1  SHALL hold the current stage.
REQ-009 flush  input  1  SHALL abort the current instruction.
REQ-010 skip_mask  input  NUM_STAGES  SHALL give the per-instruction stage-skip bits; bit 0 is ignored.
REQ-011 stage_go  output  NUM_STAGES  SHALL be the one-hot stage strobe.
REQ-012 stage_idx  output  STAGE_W  SHALL be the current stage index.
REQ-013 busy  output  1  SHALL be high while in RUN.
REQ-014 retire  output  1  SHALL be a one-cycle instruction-complete pulse.
REQ-015 retire_count  output  CNT_W  SHALL count retired instructions.
REQ-016 cycle_count  output  CNT_W  SHALL count cycles spent in RUN.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-018 In IDLE with run=1, the block SHALL enter RUN with stage_idx=0 on the next edge; in IDLE with run=0 it SHALL stay in IDLE.
REQ-019 In IDLE, stage_go and retire SHALL be 0, and flush and stall SHALL be ignored.
REQ-020 stage_go[i] SHALL equal (state==RUN && stage_idx==i && !stall && !flush), combinational from registered state.
REQ-021 With stall=1 in RUN (and flush=0), stage_idx, the latched mask and retire_count SHALL hold, and cycle_count SHALL still increment.
REQ-022 When stage_go[0] fires, bits [NUM_STAGES-1:1] of skip_mask SHALL be latched as the instruction mask; the latched bit 0 is always 0.
REQ-023 Advance target: the next stage SHALL be the lowest index j > stage_idx whose mask bit is 0.
REQ-024 In stage 0 the live skip_mask SHALL be used to compute the advance target; in later stages the latched mask SHALL be used.
REQ-025 If no such j exists, the current stage is final: retire SHALL be 1 in the same cycle as that stage_go.
REQ-026 After a final stage with run=1, stage_idx SHALL become 0 and the block SHALL remain in RUN.
REQ-027 After a final stage with run=0, the block SHALL go to IDLE with stage_idx=0.
REQ-028 Dropping run mid-instruction SHALL NOT abort it; the instruction SHALL complete first.
REQ-029 flush=1 in RUN SHALL take priority over stall and over final-stage completion: stage_go=0, retire=0, and next stage_idx=0.
REQ-030 After a flush the block SHALL remain in RUN if run=1 and go to IDLE otherwise; retire_count SHALL be unchanged.
REQ-031 retire_count SHALL increment by 1 on each retire and wrap modulo 2^CNT_W.
REQ-032 cycle_count SHALL increment every RUN cycle and wrap modulo 2^CNT_W; it SHALL hold in IDLE.
REQ-033 Latency: an instruction with k non-skipped stages and no stalls SHALL take exactly k cycles from its stage_go[0] to retire inclusive.

Reset
REQ-034 With nreset=0 at a rising edge, the block SHALL enter IDLE and set stage_idx=0, latched mask=0, retire_count=0 and cycle_count=0, regardless of any other input.
REQ-035 Reset asserted mid-instruction SHALL discard that instruction without a retire; on the following cycle stage_go=0, busy=0 and retire=0.

Verification
REQ-036 Reset, then run=1, skip_mask=0 -> stage_go = 00001, 00010, 00100, 01000, 10000 on consecutive cycles; retire with 10000; retire_count=1.
REQ-037 skip_mask=01000 during stage 0 -> stages 0, 1, 2, 4 visited; retire on the 4th cycle; stage 3 never strobed.
REQ-038 stall=1 for 3 cycles in stage 2 -> stage_go=0 and stage_idx=2 for those 3 cycles; the instruction retires at cycle 8; cycle_count=8.
REQ-039 flush=1 in stage 3 -> that cycle stage_go=0 and retire=0; next cycle stage_idx=0; retire_count unchanged.
REQ-040 run dropped during stage 1 -> stages 2..4 complete, retire pulses, then IDLE with busy=0 and stage_go=0.
REQ-041 With CNT_W=4, 16 retires -> retire_count=0; nreset=0 in stage 2 -> next cycle all outputs 0.
